// File: rtl/chain_sink_fifo_if.sv
// Handshake and status bundle between the register-chain sink FIFO and its consumer.
// The drop_cnt signal exists only when CHAIN_SINK_DROP_CNT_EN is defined.
interface chain_sink_fifo_if #(
  parameter int REG_WIDTH = 4,
  parameter int ADDR_W    = 2
);
  logic                 in_valid;
  logic [REG_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] out_data;
  logic [ADDR_W:0]      count;
  logic                 full;
  logic                 empty;
  logic                 ovf_clr;
  logic                 overflow;
`ifdef CHAIN_SINK_DROP_CNT_EN
  logic [7:0]           drop_cnt;

  modport master (
    output in_valid, in_data, out_ready, ovf_clr,
    input  out_valid, out_data, count, full, empty, overflow, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, ovf_clr,
    output out_valid, out_data, count, full, empty, overflow, drop_cnt
  );
`else
  modport master (
    output in_valid, in_data, out_ready, ovf_clr,
    input  out_valid, out_data, count, full, empty, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready, ovf_clr,
    output out_valid, out_data, count, full, empty, overflow
  );
`endif
endinterface

// File: rtl/chain_sink_fifo.sv
// First-word-fall-through sink FIFO behind the free-running register chain; flags words lost while full.
// Optional saturating drop counter is built when CHAIN_SINK_DROP_CNT_EN is defined.
module chain_sink_fifo #(
  parameter int REG_WIDTH = 4,
  parameter int ADDR_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  chain_sink_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [REG_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [ADDR_W:0]      count_q;
  logic                 overflow_q;
  logic                 full_w;
  logic                 empty_w;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign full_w  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_w = (count_q == '0);

  // The upstream chain cannot stall, so a full FIFO only takes a word when the consumer frees a slot.
  assign pop  = !empty_w && bus.out_ready;
  assign push = bus.in_valid && (!full_w || pop);
  assign drop = bus.in_valid && full_w && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push && !pop)      count_q <= count_q + (ADDR_W+1)'(1);
      else if (pop && !push) count_q <= count_q - (ADDR_W+1)'(1);
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)             overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

`ifdef CHAIN_SINK_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (bus.ovf_clr) begin
      drop_cnt_q <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

  assign bus.out_data  = empty_w ? '0 : mem[rd_ptr];
  assign bus.out_valid = !empty_w;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_chain_sink_fifo.sv
// Scoreboard bench for chain_sink_fifo: a queue-based FIFO model predicts accepted words and status.
// Honours CHAIN_SINK_DROP_CNT_EN to also check the drop counter.
module tb_chain_sink_fifo;
  localparam int REG_WIDTH = 4;
  localparam int ADDR_W    = 2;
  localparam int DEPTH     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  chain_sink_fifo_if #(.REG_WIDTH(REG_WIDTH), .ADDR_W(ADDR_W)) bus ();

  chain_sink_fifo #(.REG_WIDTH(REG_WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [REG_WIDTH-1:0] sb [$];
  int modelCount = 0;
  int modelOverflow = 0;
  int modelDropCnt = 0;

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkStatus();
    checkOutput("count", int'(bus.count), modelCount);
    checkOutput("empty", int'(bus.empty), (modelCount == 0) ? 1 : 0);
    checkOutput("full", int'(bus.full), (modelCount == DEPTH) ? 1 : 0);
    checkOutput("overflow", int'(bus.overflow), modelOverflow);
`ifdef CHAIN_SINK_DROP_CNT_EN
    checkOutput("drop_cnt", int'(bus.drop_cnt), modelDropCnt);
`endif
  endtask

  // One cycle: drive at the falling edge, predict from the model, update it after the rising edge.
  task automatic applyStimulus(input bit inValid, input int inData, input bit outReady, input bit ovfClr);
    bit doPop, doPush, doDrop;
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = inValid;
    bus.in_data   = REG_WIDTH'(inData);
    bus.out_ready = outReady;
    bus.ovf_clr   = ovfClr;
    doPop  = (modelCount > 0) && outReady;
    doPush = inValid && ((modelCount < DEPTH) || doPop);
    doDrop = inValid && (modelCount == DEPTH) && !doPop;
    @(posedge clk);
    #1;
    if (doPush) sb.push_back(REG_WIDTH'(inData));
    modelCount = modelCount + (doPush ? 1 : 0) - (doPop ? 1 : 0);
    if (doDrop) modelOverflow = 1;
    else if (ovfClr) modelOverflow = 0;
    if (ovfClr) modelDropCnt = doDrop ? 1 : 0;
    else if (doDrop && modelDropCnt < 255) modelDropCnt++;
    checkStatus();
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    modelCount    = 0;
    modelOverflow = 0;
    modelDropCnt  = 0;
    checkStatus();
    checkOutput("out_valid_rst", int'(bus.out_valid), 0);
    checkOutput("out_data_rst", int'(bus.out_data), 0);
  endtask

  // Monitor: mid-cycle, compare the presented head against the scoreboard and retire it on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        checkOutput("out_valid", int'(bus.out_valid), (sb.size() != 0) ? 1 : 0);
        if (!bus.out_valid) begin
          checkOutput("out_data_empty", int'(bus.out_data), 0);
        end else if (sb.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          checkOutput("out_data", int'(bus.out_data), int'(sb[0]));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    applyReset();
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

    // Three words held, then drained in order
    for (int i = 1; i <= 3; i++) applyStimulus(1, i, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);

    // Fill, drop one, then push-while-full with a same-cycle pop
    for (int i = 10; i <= 13; i++) applyStimulus(1, i, 0, 0);
    applyStimulus(1, 14, 0, 0);
    applyStimulus(1, 5, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0);

    // Streaming through an otherwise empty FIFO
    for (int i = 0; i < 10; i++) applyStimulus(1, i, 1, 0);
    applyStimulus(0, 0, 1, 0);

    // Clear colliding with a drop, then a plain clear, then reset with words stored
    for (int i = 0; i < 4; i++) applyStimulus(1, i + 6, 0, 0);
    applyStimulus(1, 15, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);
    applyReset();

    // Random traffic, biased toward filling so drops and saturation-free counting are exercised
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chain_sink_fifo.md
# chain_sink_fifo

Elastic sink stage placed directly downstream of the register-chain delay line. It captures the chain's free-running output words, qualified by a valid strobe, into a small first-word-fall-through FIFO. It presents them to the consumer on a valid/ready handshake. Because the upstream chain cannot be stalled, the block detects and flags any word dropped while the FIFO is full.

## Interface
- `REG_WIDTH`, default 4: data word width; matches the upstream chain.
- `ADDR_W`, default 2: FIFO address width; depth `DEPTH = 2**ADDR_W` (4 by default); `ADDR_W >= 1`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word present this cycle.
- `in_data`  in  REG_WIDTH  upstream word (chain output).
- `out_valid`  out  1  FIFO non-empty; `out_data` is meaningful.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  REG_WIDTH  head word; 0 when empty.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `ovf_clr`  in  1  clears the sticky overflow state.
- `overflow`  out  1  sticky; set when an input word is dropped.
- `drop_cnt`  out  8  saturating dropped-word counter; present only with `CHAIN_SINK_DROP_CNT_EN`.

## Operation
- `pop` = `out_valid && out_ready`.
- `push` = `in_valid && (!full || pop)`. When full, a same-cycle pop frees the slot, so the word is accepted.
- `drop` = `in_valid && full && !pop`. The word is discarded and storage is unchanged.
- Storage: `DEPTH` × `REG_WIDTH` register array with write pointer `wr_ptr` and read pointer `rd_ptr`, each `ADDR_W` bits. Both pointers wrap modulo `DEPTH` naturally.
- Push: `mem[wr_ptr] <= in_data` and `wr_ptr` increments.
- Pop: `rd_ptr` increments.
- `count` update per cycle:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together, or on neither
- `out_data` = `empty ? 0 : mem[rd_ptr]`. This is combinational from registered state, so the FIFO is first-word-fall-through.
- `out_valid` = `!empty`. `full`, `empty` and `count` are registered state or decoded directly from it.
- Overflow: `drop` sets `overflow`. `ovf_clr` clears it. If `drop` and `ovf_clr` occur in the same cycle, the set wins and `overflow` reads 1.
- Consumer rule: `out_ready` while `!out_valid` has no effect. Pointers never move on an empty FIFO.

## Timing
- Reset values (`rst` sampled high at an edge): `wr_ptr=0`, `rd_ptr=0`, `count=0`, `empty=1`, `full=0`, `out_valid=0`, `out_data=0`, `overflow=0`, `drop_cnt=0`. Array contents are not reset.
- `rst` has priority over all other inputs. Asserting it mid-stream discards every stored word on that edge.
- Latency: a word pushed at edge N is visible on `out_data` with `out_valid=1` right after edge N, i.e. one cycle from input to output.
- Throughput: one push and one pop per cycle sustained; no bubble at full or empty.
- Empty with simultaneous push: there is no combinational bypass. `out_valid` stays 0 in that cycle.
- `overflow` and `drop_cnt` update on the edge at which `drop` is sampled.

## Configuration
- `CHAIN_SINK_DROP_CNT_EN` defined:
  - The `drop_cnt` port and its 8-bit counter are built.
  - The counter increments on each `drop` and saturates at 255.
  - `ovf_clr` resets it to 0.
  - If `ovf_clr` and `drop` coincide, `drop_cnt` becomes 1.
- Not defined: the port and counter are absent; the `overflow` flag alone reports loss.

## Test plan
- Reset then idle → `empty=1`, `count=0`, `out_valid=0`, `out_data=0`, `overflow=0`.
- Push 0x1, 0x2, 0x3 on consecutive cycles with `out_ready=0`, then hold `out_ready=1` → `count` reaches 3; output sequence is 0x1, 0x2, 0x3; then `empty=1`.
- Fill with 0xA, 0xB, 0xC, 0xD, then push 0xE with `out_ready=0` → `full=1`, `overflow=1` (with macro, `drop_cnt=1`); drain yields 0xA..0xD only.
- While full, push 0x5 with `out_ready=1` in the same cycle → no drop; `count` stays 4; the last word drained is 0x5; `overflow` unchanged.
- Continuous push with `out_ready=1` for 10 cycles, data 0..9 → outputs 0..9 in order, each one cycle later; `count` stays 1; pointers wrap twice.
- With `overflow=1`, assert `ovf_clr` and a drop in the same cycle → `overflow=1` (with macro, `drop_cnt=1`). Next cycle, `ovf_clr` alone → `overflow=0`. Then assert `rst` with 3 words stored → `count=0` after the edge.
